tank_hit_detect: RTL

- Per-frame collision checker; sits directly upstream of the round/game state controller.
- Scans the bullet slot table once per video frame and tests each live bullet against both tank bounding boxes.
- Produces the latched tank1shot/tank2shot level outputs the controller consumes.
- Issues a kill pulse so the bullet manager frees the slot that scored the hit.

---
 rtl/tank_hit_detect_pkg.sv | 23 ++
 rtl/tank_hit_detect_if.sv | 31 +++
 rtl/tank_hit_detect_aabb_overlap.sv | 32 +++
 rtl/tank_hit_detect.sv | 108 ++++++++++
 4 files changed

// File: rtl/tank_hit_detect_pkg.sv
// Shared definitions for the tank collision checker: screen geometry,
// game_end encodings seen from the round controller, and the scan FSM states.
package tank_pkg;

  localparam int COORD_W     = 10;
  localparam int TANK_SIZE   = 16;
  localparam int BULLET_SIZE = 4;

  typedef enum logic [1:0] {
    IN_PLAY = 2'b00,
    T1WIN   = 2'b01,
    T2WIN   = 2'b10,
    START   = 2'b11
  } game_end_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ADDR  = 2'b01,
    S_CHECK = 2'b10,
    S_DONE  = 2'b11
  } hit_state_e;

endpackage

// File: rtl/tank_hit_detect_if.sv
// Bullet slot table link: the checker addresses a slot and gets its contents
// back one cycle later, and tells the bullet manager which slot to free.
interface bullet_tbl_if #(
  parameter int NUM_BULLETS = 8
);
  import tank_pkg::*;

  localparam int IDX_W = $clog2(NUM_BULLETS);

  logic [IDX_W-1:0]   bullet_idx;
  logic               bullet_valid;
  logic [COORD_W-1:0] bullet_x;
  logic [COORD_W-1:0] bullet_y;
  logic               bullet_owner;
  logic [2:0]         bullet_age;
  logic               bullet_kill;
  logic [IDX_W-1:0]   kill_idx;

  // Hit checker side: reads slots, issues kills.
  modport master (
    output bullet_idx, bullet_kill, kill_idx,
    input  bullet_valid, bullet_x, bullet_y, bullet_owner, bullet_age
  );

  // Bullet manager side: serves slots, consumes kills.
  modport slave (
    input  bullet_idx, bullet_kill, kill_idx,
    output bullet_valid, bullet_x, bullet_y, bullet_owner, bullet_age
  );

endinterface

// File: rtl/tank_hit_detect_aabb_overlap.sv
// Combinational axis-aligned box overlap test between box A (size A_SIZE)
// and box B (size B_SIZE), both given by their top-left corners.
module aabb_overlap #(
  parameter int W      = 10,
  parameter int A_SIZE = 16,
  parameter int B_SIZE = 4
) (
  input  logic [W-1:0] a_x_i,
  input  logic [W-1:0] a_y_i,
  input  logic [W-1:0] b_x_i,
  input  logic [W-1:0] b_y_i,
  output logic         hit_o
);

  // One extra bit so far edges near the bottom/right of the screen never wrap.
  typedef logic [W:0] ext_t;
  localparam ext_t A_EXT = ext_t'(A_SIZE);
  localparam ext_t B_EXT = ext_t'(B_SIZE);

  ext_t ax, ay, bx, by;

  // Strict inequalities: boxes that only share an edge do not overlap.
  always_comb begin
    ax    = {1'b0, a_x_i};
    ay    = {1'b0, a_y_i};
    bx    = {1'b0, b_x_i};
    by    = {1'b0, b_y_i};
    hit_o = (bx < ax + A_EXT) && (bx + B_EXT > ax) &&
            (by < ay + A_EXT) && (by + B_EXT > ay);
  end

endmodule

// File: rtl/tank_hit_detect.sv
// Per-frame collision checker. On frame_start it walks every bullet slot
// (address cycle, then check cycle), tests live bullets against both tanks,
// pulses a kill for each slot that scores, and latches tank1shot/tank2shot
// until the round controller reports the round is over.
module tank_hit_detect
  import tank_pkg::*;
#(
  parameter int NUM_BULLETS  = 8,
  parameter int GRACE_FRAMES = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               frame_start,
  input  logic [1:0]         game_end,
  input  logic [COORD_W-1:0] tank1_x,
  input  logic [COORD_W-1:0] tank1_y,
  input  logic [COORD_W-1:0] tank2_x,
  input  logic [COORD_W-1:0] tank2_y,
  bullet_tbl_if.master       bus,
  output logic               tank1shot,
  output logic               tank2shot,
  output logic               scan_busy
);

  localparam int IDX_W = $clog2(NUM_BULLETS);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_BULLETS - 1);

  hit_state_e       state_q, state_d;
  logic [IDX_W-1:0] slot_q, slot_d;
  logic             kill_q, kill_d;
  logic [IDX_W-1:0] kill_idx_q, kill_idx_d;
  logic             t1_q, t1_d, t2_q, t2_d;
  logic             ov1, ov2, in_grace, hit1, hit2, in_play;

  aabb_overlap #(.W(COORD_W), .A_SIZE(TANK_SIZE), .B_SIZE(BULLET_SIZE)) u_ov_tank1 (
    .a_x_i(tank1_x), .a_y_i(tank1_y), .b_x_i(bus.bullet_x), .b_y_i(bus.bullet_y), .hit_o(ov1)
  );

  aabb_overlap #(.W(COORD_W), .A_SIZE(TANK_SIZE), .B_SIZE(BULLET_SIZE)) u_ov_tank2 (
    .a_x_i(tank2_x), .a_y_i(tank2_y), .b_x_i(bus.bullet_x), .b_y_i(bus.bullet_y), .hit_o(ov2)
  );

  // Scan sequencing, hit qualification and flag next-state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    slot_d     = slot_q;
    kill_d     = 1'b0;
    kill_idx_d = kill_idx_q;
    hit1       = 1'b0;
    hit2       = 1'b0;
    in_play    = (game_end == IN_PLAY);
    // A freshly fired bullet is still inside its owner's box; ignore that.
    in_grace   = int'(bus.bullet_age) < GRACE_FRAMES;

    case (state_q)
      S_IDLE: begin
        slot_d = '0;
        if (frame_start && in_play && !t1_q && !t2_q) state_d = S_ADDR;
      end
      S_ADDR: state_d = S_CHECK;
      S_CHECK: begin
        hit1 = bus.bullet_valid && ov1 && !(bus.bullet_owner == 1'b0 && in_grace);
        hit2 = bus.bullet_valid && ov2 && !(bus.bullet_owner == 1'b1 && in_grace);
        if (hit1 || hit2) begin
          kill_d     = 1'b1;
          kill_idx_d = slot_q;
        end
        slot_d  = slot_q + IDX_W'(1);
        state_d = (slot_q == LAST_SLOT) ? S_DONE : S_ADDR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new hit sets the flag; otherwise it holds until the controller leaves play.
    t1_d = hit1 ? 1'b1 : (in_play ? t1_q : 1'b0);
    t2_d = hit2 ? 1'b1 : (in_play ? t2_q : 1'b0);
  end

  // State registers with synchronous reset; reset mid-scan drops any pending kill.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (RESET) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      kill_q     <= 1'b0;
      kill_idx_q <= '0;
      t1_q       <= 1'b0;
      t2_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      kill_q     <= kill_d;
      kill_idx_q <= kill_idx_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
    end
  end

  assign bus.bullet_idx  = slot_q;
  assign bus.bullet_kill = kill_q;
  assign bus.kill_idx    = kill_idx_q;
  assign tank1shot       = t1_q;
  assign tank2shot       = t2_q;
  assign scan_busy       = (state_q != S_IDLE);

endmodule
